// File: rtl/layer1_asm_sched.sv
// Sequencer for the 8-lane layer-1 ASM array and its 16-bit output packer.
// Per group: BN fetch, TAPS operand beats, send, 4-beat collect, high-word write-back.
module layer1_asm_sched #(
    parameter int LANES  = 8,
    parameter int TAPS   = 9,
    parameter int GRP_W  = 10,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [GRP_W-1:0]  num_grp_i,
    input  logic              src_valid_i,
    output logic [ADDR_W-1:0] pix_addr_o,
    output logic [ADDR_W-1:0] wgt_addr_o,
    output logic [ADDR_W-1:0] bn_addr_o,
    output logic [LANES-1:0]  asm_reception_o,
    output logic [LANES-1:0]  asm_send_o,
    output logic              calculate_en_o,
    output logic              out_we_o,
    output logic [ADDR_W:0]   out_addr_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_BN, S_ACC, S_SEND, S_COL, S_WB, S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [GRP_W-1:0] g_q, g_d;
    logic [GRP_W-1:0] n_q, n_d;
    logic [TW-1:0]    t_q, t_d;
    logic [1:0]       b_q, b_d;
    logic             done_q, done_d;
    logic             rec_en;
    logic             send_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            n_q     <= '0;
            t_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            n_q     <= n_d;
            t_q     <= t_d;
            b_q     <= b_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        g_d            = g_q;
        n_d            = n_q;
        t_d            = t_q;
        b_d            = b_q;
        rec_en         = 1'b0;
        send_en        = 1'b0;
        pix_addr_o     = '0;
        wgt_addr_o     = '0;
        bn_addr_o      = '0;
        calculate_en_o = 1'b0;
        out_we_o       = 1'b0;
        out_addr_o     = '0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_d     = num_grp_i;
                    g_d     = '0;
                    t_d     = '0;
                    b_d     = '0;
                    state_d = (num_grp_i == '0) ? S_FIN : S_BN;
                end
            end
            S_BN: begin
                bn_addr_o = ADDR_W'(g_q);
                t_d       = '0;
                state_d   = S_ACC;
            end
            S_ACC: begin
                // Addresses stay driven through a stall; only the beat strobe drops.
                pix_addr_o = ADDR_W'(g_q) * ADDR_W'(TAPS) + ADDR_W'(t_q);
                wgt_addr_o = ADDR_W'(t_q);
                if (src_valid_i) begin
                    rec_en = 1'b1;
                    if (t_q == TW'(TAPS - 1)) begin
                        t_d     = '0;
                        state_d = S_SEND;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            S_SEND: begin
                send_en = 1'b1;
                b_d     = '0;
                state_d = S_COL;
            end
            S_COL: begin
                calculate_en_o = 1'b1;
                b_d            = b_q + 2'd1;
                // Low word is complete after two captured bytes.
                if (b_q == 2'd2) begin
                    out_we_o   = 1'b1;
                    out_addr_o = (ADDR_W + 1)'({g_q, 1'b0});
                end
                if (b_q == 2'd3) state_d = S_WB;
            end
            S_WB: begin
                out_we_o   = 1'b1;
                out_addr_o = (ADDR_W + 1)'({g_q, 1'b1});
                if (g_q == n_q - GRP_W'(1)) begin
                    state_d = S_FIN;
                end else begin
                    g_d     = g_q + GRP_W'(1);
                    state_d = S_BN;
                end
            end
            S_FIN: begin
                g_d     = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign done_d = (state_q == S_FIN);
    assign done_o = done_q;
    assign busy_o = (state_q != S_IDLE) && (state_q != S_FIN);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign asm_reception_o[gi] = rec_en;
        assign asm_send_o[gi]      = send_en;
    end

endmodule

// File: tb/tb_layer1_asm_sched.sv
// Directed bench for layer1_asm_sched: reset, single/multi-group runs, stall,
// empty run and mid-run abort, with hand-derived cycle-by-cycle expectations.
module tb_layer1_asm_sched;

    localparam int LANES  = 8;
    localparam int TAPS   = 9;
    localparam int GRP_W  = 10;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start_i = 1'b0;
    logic [GRP_W-1:0]  num_grp_i = '0;
    logic              src_valid_i = 1'b0;
    logic [ADDR_W-1:0] pix_addr_o, wgt_addr_o, bn_addr_o;
    logic [LANES-1:0]  asm_reception_o, asm_send_o;
    logic              calculate_en_o, out_we_o, busy_o, done_o;
    logic [ADDR_W:0]   out_addr_o;

    int n_checks = 0;
    int n_fail   = 0;

    layer1_asm_sched #(.LANES(LANES), .TAPS(TAPS), .GRP_W(GRP_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .num_grp_i(num_grp_i),
        .src_valid_i(src_valid_i), .pix_addr_o(pix_addr_o), .wgt_addr_o(wgt_addr_o),
        .bn_addr_o(bn_addr_o), .asm_reception_o(asm_reception_o), .asm_send_o(asm_send_o),
        .calculate_en_o(calculate_en_o), .out_we_o(out_we_o), .out_addr_o(out_addr_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] all_outs();
        return 64'({pix_addr_o, wgt_addr_o, bn_addr_o, asm_reception_o, asm_send_o,
                    calculate_en_o, out_we_o, out_addr_o, busy_o, done_o});
    endfunction

    // Entered at the negedge of a BN cycle; returns at the negedge after WB.
    task automatic run_group(input int g, input int stall_t, input int stall_n);
        #1;
        n_checks++;
        if (bn_addr_o !== ADDR_W'(g) || busy_o !== 1'b1 || asm_reception_o !== 8'h00) begin
            n_fail++;
            $display("FAIL bn g=%0d: bn_addr=%0d busy=%b rec=%h required bn_addr=%0d busy=1 rec=00",
                     g, bn_addr_o, busy_o, asm_reception_o, g);
        end
        for (int t = 0; t < TAPS; t++) begin
            if (t == stall_t) begin
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk); src_valid_i = 1'b0; #1;
                    n_checks++;
                    if (asm_reception_o !== 8'h00 || pix_addr_o !== ADDR_W'(g * TAPS + t) ||
                        wgt_addr_o !== ADDR_W'(t)) begin
                        n_fail++;
                        $display("FAIL stall g=%0d t=%0d: rec=%h pix=%0d wgt=%0d required rec=00 pix=%0d wgt=%0d",
                                 g, t, asm_reception_o, pix_addr_o, wgt_addr_o, g * TAPS + t, t);
                    end
                end
            end
            @(negedge clk); src_valid_i = 1'b1; #1;
            n_checks++;
            if (asm_reception_o !== 8'hFF || asm_send_o !== 8'h00 ||
                pix_addr_o !== ADDR_W'(g * TAPS + t) || wgt_addr_o !== ADDR_W'(t)) begin
                n_fail++;
                $display("FAIL acc g=%0d t=%0d: rec=%h send=%h pix=%0d wgt=%0d required rec=FF send=00 pix=%0d wgt=%0d",
                         g, t, asm_reception_o, asm_send_o, pix_addr_o, wgt_addr_o, g * TAPS + t, t);
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if (asm_send_o !== 8'hFF || asm_reception_o !== 8'h00 || calculate_en_o !== 1'b0 || out_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL send g=%0d: send=%h rec=%h calc=%b we=%b required send=FF rec=00 calc=0 we=0",
                     g, asm_send_o, asm_reception_o, calculate_en_o, out_we_o);
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk); #1;
            n_checks++;
            if (calculate_en_o !== 1'b1 || out_we_o !== (b == 2) || asm_send_o !== 8'h00 ||
                (b == 2 && out_addr_o !== (ADDR_W + 1)'(2 * g))) begin
                n_fail++;
                $display("FAIL col g=%0d b=%0d: calc=%b we=%b send=%h out_addr=%0d required calc=1 we=%0d send=00 out_addr=%0d",
                         g, b, calculate_en_o, out_we_o, asm_send_o, out_addr_o, (b == 2), 2 * g);
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if (calculate_en_o !== 1'b0 || out_we_o !== 1'b1 || out_addr_o !== (ADDR_W + 1)'(2 * g + 1) || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wb g=%0d: calc=%b we=%b out_addr=%0d done=%b required calc=0 we=1 out_addr=%0d done=0",
                     g, calculate_en_o, out_we_o, out_addr_o, done_o, 2 * g + 1);
        end
        $display("group g=%0d checked (stall_t=%0d stall_n=%0d)", g, stall_t, stall_n);
        @(negedge clk);
    endtask

    task automatic start_run(input int n);
        @(negedge clk); start_i = 1'b1; num_grp_i = GRP_W'(n);
        @(negedge clk); start_i = 1'b0;
    endtask

    // Entered at the negedge of the FIN cycle.
    task automatic expect_done(input string name);
        #1;
        n_checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || out_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s fin: done=%b busy=%b we=%b required 0 0 0", name, done_o, busy_o, out_we_o);
        end
        @(negedge clk); #1;
        n_checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done: done=%b busy=%b required done=1 busy=0", name, done_o, busy_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (all_outs() !== 64'd0) begin
                n_fail++;
                $display("FAIL %s idle%0d: outputs=%h required 0", name, i, all_outs());
            end
        end
        $display("run %s completed", name);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_checks++;
        if (all_outs() !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs=%h required 0", all_outs());
        end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (all_outs() !== 64'd0) begin
                n_fail++;
                $display("FAIL reset_idle%0d: outputs=%h required 0", i, all_outs());
            end
        end
        $display("reset idle checked");
    endtask

    task automatic test_single();
        start_run(1);
        run_group(0, -1, 0);
        expect_done("single");
    endtask

    task automatic test_multi();
        start_run(3);
        run_group(0, -1, 0);
        // A start during the run must not relatch the group count.
        start_i = 1'b1; num_grp_i = GRP_W'(5);
        run_group(1, -1, 0);
        start_i = 1'b0;
        run_group(2, -1, 0);
        expect_done("multi");
    endtask

    task automatic test_stall();
        start_run(1);
        run_group(0, 4, 3);
        expect_done("stall");
    endtask

    task automatic test_zero();
        start_run(0);
        expect_done("zero");
    endtask

    task automatic test_abort();
        start_run(2);
        for (int i = 0; i < 12; i++) @(negedge clk);
        #1;
        n_checks++;
        if (calculate_en_o !== 1'b1 || out_we_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pos: calc=%b we=%b busy=%b required calc=1 we=0 busy=1",
                     calculate_en_o, out_we_o, busy_o);
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (all_outs() !== 64'd0) begin
            n_fail++;
            $display("FAIL abort_async: outputs=%h required 0", all_outs());
        end
        @(negedge clk); @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (all_outs() !== 64'd0) begin
                n_fail++;
                $display("FAIL abort_quiet%0d: outputs=%h required 0", i, all_outs());
            end
        end
        start_run(1);
        run_group(0, -1, 0);
        expect_done("after_abort");
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_zero();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
